// File: rtl/tm_anasymod.sv
// Emulation time manager: min-reduces per-source timestep requests into emu_dt and accumulates emu_time.
// Optional stall detector (emu_stall port) is built when TM_STALL_DET_EN is defined.
`ifndef DT_WIDTH
`define DT_WIDTH 32
`endif
`ifndef TIME_WIDTH
`define TIME_WIDTH 64
`endif

module tm_anasymod #(
  parameter int N_SRC      = 2,
  parameter int DT_WIDTH   = `DT_WIDTH,
  parameter int TIME_WIDTH = `TIME_WIDTH,
  parameter int STEP_WIDTH = 32,
  parameter int STALL_THR  = 1024
) (
  input  logic                      emu_clk,
  input  logic                      emu_rst,
  input  logic [N_SRC*DT_WIDTH-1:0] dt_req,
  input  logic [N_SRC-1:0]          dt_req_en,
  output logic [DT_WIDTH-1:0]       emu_dt,
  output logic [TIME_WIDTH-1:0]     emu_time,
  output logic [STEP_WIDTH-1:0]     emu_step_cnt,
`ifdef TM_STALL_DET_EN
  output logic                      emu_stall,
`endif
  output logic                      emu_time_sat
);

  localparam int LV = $clog2(N_SRC);
  localparam int P  = 1 << LV;

  // Leaves beyond N_SRC and disabled sources are all-ones so they never win the min.
  genvar l, j;
  generate
    for (l = 0; l <= LV; l++) begin : g_lvl
      localparam int W = P >> l;
      logic [DT_WIDTH-1:0] v [W];
      for (j = 0; j < W; j++) begin : g_node
        if (l == 0) begin : g_leaf
          if (j < N_SRC) begin : g_src
            assign v[j] = dt_req_en[j] ? dt_req[j*DT_WIDTH +: DT_WIDTH] : '1;
          end else begin : g_pad
            assign v[j] = '1;
          end
        end else begin : g_min
          assign v[j] = (g_lvl[l-1].v[2*j] < g_lvl[l-1].v[2*j+1]) ?
                        g_lvl[l-1].v[2*j] : g_lvl[l-1].v[2*j+1];
        end
      end
    end
  endgenerate

  assign emu_dt = g_lvl[LV].v[0];

  logic [TIME_WIDTH:0] dt_ext;
  logic [TIME_WIDTH:0] sum;
  logic                dt_nz;

  assign dt_ext = (TIME_WIDTH+1)'(emu_dt);
  assign sum    = {1'b0, emu_time} + dt_ext;
  assign dt_nz  = (emu_dt != '0);

  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      emu_time     <= '0;
      emu_step_cnt <= '0;
      emu_time_sat <= 1'b0;
    end else begin
      if (sum[TIME_WIDTH]) begin
        emu_time     <= '1;
        emu_time_sat <= 1'b1;
      end else begin
        emu_time <= sum[TIME_WIDTH-1:0];
      end
      if (dt_nz) emu_step_cnt <= emu_step_cnt + 1'b1;
    end
  end

`ifdef TM_STALL_DET_EN
  localparam int SW = $clog2(STALL_THR + 1);
  localparam logic [SW-1:0] THR = SW'(STALL_THR);

  logic [SW-1:0] stall_cnt;
  logic [SW-1:0] stall_cnt_nxt;

  always_comb begin
    stall_cnt_nxt = '0;
    if (!dt_nz) stall_cnt_nxt = (stall_cnt == THR) ? THR : stall_cnt + 1'b1;
  end

  // Flag is registered from the next count so it rises on the completing edge.
  always_ff @(posedge emu_clk) begin
    if (emu_rst) begin
      stall_cnt <= '0;
      emu_stall <= 1'b0;
    end else begin
      stall_cnt <= stall_cnt_nxt;
      emu_stall <= (stall_cnt_nxt == THR);
    end
  end
`endif

endmodule

// File: tb/tb_tm_anasymod.sv
// Randomized bench for tm_anasymod against a plain-arithmetic reference model.
module tb_tm_anasymod;
  localparam int NS = 3;
  localparam int DW = 8;
  localparam int TW = 8;
  localparam int SW = 8;
  localparam int THR = 4;

  logic              emu_clk = 1'b0;
  logic              emu_rst;
  logic [NS*DW-1:0]  dt_req;
  logic [NS-1:0]     dt_req_en;
  logic [DW-1:0]     emu_dt;
  logic [TW-1:0]     emu_time;
  logic [SW-1:0]     emu_step_cnt;
  logic              emu_time_sat;
`ifdef TM_STALL_DET_EN
  logic              emu_stall;
`endif

  tm_anasymod #(.N_SRC(NS), .DT_WIDTH(DW), .TIME_WIDTH(TW), .STEP_WIDTH(SW), .STALL_THR(THR)) dut (
    .emu_clk(emu_clk),
    .emu_rst(emu_rst),
    .dt_req(dt_req),
    .dt_req_en(dt_req_en),
    .emu_dt(emu_dt),
    .emu_time(emu_time),
    .emu_step_cnt(emu_step_cnt),
`ifdef TM_STALL_DET_EN
    .emu_stall(emu_stall),
`endif
    .emu_time_sat(emu_time_sat)
  );

  always #5 emu_clk = ~emu_clk;

  int n_cmp = 0;
  int n_bad = 0;

  int req [NS];
  bit en  [NS];
  int m_time, m_cnt, m_zrun;
  bit m_sat;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_dt();
    int m = (1 << DW) - 1;
    for (int i = 0; i < NS; i++)
      if (en[i] && req[i] < m) m = req[i];
    return m;
  endfunction

  task automatic apply();
    for (int i = 0; i < NS; i++) begin
      dt_req[i*DW +: DW] = DW'(req[i]);
      dt_req_en[i] = en[i];
    end
  endtask

  task automatic set_req(input int r0, input int r1, input int r2, input bit [2:0] e);
    req[0] = r0; req[1] = r1; req[2] = r2;
    for (int i = 0; i < NS; i++) en[i] = e[i];
    apply();
  endtask

  // One clock: check combinational dt, clock it, advance the model, check registered state.
  task automatic cycle(input bit rst);
    int d;
    emu_rst = rst;
    #1;
    d = model_dt();
    check("emu_dt", emu_dt, d);
    @(posedge emu_clk);
    #1;
    if (rst) begin
      m_time = 0; m_cnt = 0; m_sat = 0; m_zrun = 0;
    end else begin
      if (m_time + d > (1 << TW) - 1) begin
        m_time = (1 << TW) - 1;
        m_sat = 1;
      end else begin
        m_time = m_time + d;
      end
      if (d != 0) begin
        m_cnt = (m_cnt + 1) % (1 << SW);
        m_zrun = 0;
      end else begin
        m_zrun++;
      end
    end
    check("emu_time", emu_time, m_time);
    check("emu_step_cnt", emu_step_cnt, m_cnt);
    check("emu_time_sat", emu_time_sat, m_sat);
`ifdef TM_STALL_DET_EN
    check("emu_stall", emu_stall, (m_zrun >= THR) ? 1 : 0);
`endif
  endtask

  initial begin
    m_time = 0; m_cnt = 0; m_sat = 0; m_zrun = 0;
    set_req(5, 3, 0, 3'b011);
    cycle(1);
    cycle(1);

    // Two enabled sources 5 and 3: time 3,6,9,12, four steps.
    for (int k = 0; k < 4; k++) cycle(0);
    check("plan_time_12", emu_time, 12);
    check("plan_cnt_4", emu_step_cnt, 4);

    set_req(7, 2, 0, 3'b001);
    cycle(0);
    check("en01_dt7", emu_dt, 7);
    set_req(7, 2, 0, 3'b000);
    #1 check("en00_all_ones", emu_dt, 255);
    cycle(1);

    // Saturation: 250 then +10, then held under dt 0 and 1.
    set_req(250, 0, 0, 3'b001);
    cycle(0);
    set_req(10, 0, 0, 3'b001);
    cycle(0);
    check("sat_time", emu_time, 255);
    check("sat_flag", emu_time_sat, 1);
    set_req(0, 0, 0, 3'b001);
    cycle(0);
    set_req(1, 0, 0, 3'b001);
    cycle(0);
    check("sat_hold", emu_time, 255);

    // Pause: zero request holds time and count, then a step of 4.
    cycle(1);
    set_req(0, 9, 9, 3'b111);
    for (int k = 0; k < THR; k++) cycle(0);
    check("pause_time", emu_time, 0);
    set_req(4, 9, 9, 3'b111);
    cycle(0);
    check("pause_step", emu_time, 4);
    check("pause_cnt", emu_step_cnt, 1);

    // Mid-run reset at time 100 / count 20.
    cycle(1);
    set_req(5, 200, 100, 3'b111);
    for (int k = 0; k < 20; k++) cycle(0);
    check("pre_rst_time", emu_time, 100);
    cycle(1);
    check("rst_time", emu_time, 0);
    check("rst_cnt", emu_step_cnt, 0);
    cycle(0);
    check("resume_time", emu_time, 5);

    // Randomized phase with occasional resets and wide/zero-heavy requests.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NS; i++) begin
        case ($urandom_range(0, 9))
          0, 1:    req[i] = 0;
          2:       req[i] = $urandom_range(0, 255);
          3:       req[i] = 255;
          default: req[i] = $urandom_range(1, 6);
        endcase
        en[i] = ($urandom_range(0, 4) != 0);
      end
      apply();
      cycle($urandom_range(0, 79) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tm_anasymod.md
# tm_anasymod

Emulation time manager. Takes per-source timestep requests from the controller and analog/digital model blocks, selects the smallest as the global timestep, and advances the emulation time accumulator once per emulator clock. Sits downstream of the emulation controller's `__emu_dt_req` output. Feeds `emu_time` back to the controller and `emu_dt` to every model block.

## Interface

Parameters:
- `N_SRC`, default 2: number of timestep request sources, minimum 1.
- `DT_WIDTH`, default `` `DT_WIDTH ``: width of each request and of `emu_dt`.
- `TIME_WIDTH`, default `` `TIME_WIDTH ``: width of `emu_time`. Must satisfy `TIME_WIDTH >= DT_WIDTH`.
- `STEP_WIDTH`, default 32: width of the step counter.
- `STALL_THR`, default 1024: consecutive zero-step cycles before stall is flagged. Used only with `TM_STALL_DET_EN`.

Ports:
- `emu_clk`, in, 1: emulator clock.
- `emu_rst`, in, 1: reset; one clock; synchronous, active-high.
- `dt_req`, in, N_SRC*DT_WIDTH: packed requests; source i at `[i*DT_WIDTH +: DT_WIDTH]`.
- `dt_req_en`, in, N_SRC: per-source enable; a disabled source is treated as all-ones (no constraint).
- `emu_dt`, out, DT_WIDTH: global timestep for the current cycle.
- `emu_time`, out, TIME_WIDTH: accumulated emulation time, registered.
- `emu_step_cnt`, out, STEP_WIDTH: number of cycles with nonzero `emu_dt`, registered.
- `emu_time_sat`, out, 1: sticky flag; set when time saturated.
- `emu_stall`, out, 1: stall flag. Present only with `TM_STALL_DET_EN`.

## Operation

- `emu_dt` is the unsigned minimum over all enabled `dt_req[i]`.
  - If no source is enabled, `emu_dt` is all-ones.
  - Ties have no effect on the result; no source priority is exposed.
- Time update on each `emu_clk` rising edge, when not in reset:
  - `sum = emu_time + zero_ext(emu_dt)`, computed at TIME_WIDTH+1 bits.
  - If `sum[TIME_WIDTH]` is set: `emu_time` ← all-ones and `emu_time_sat` ← 1.
  - Otherwise: `emu_time` ← `sum[TIME_WIDTH-1:0]`.
  - Once `emu_time` is all-ones it holds there, even when `emu_dt` is 0.
- `emu_time_sat` is sticky and clears only on reset.
- `emu_step_cnt` increments by 1 on every clocked cycle with `emu_dt != 0`. It wraps modulo 2^STEP_WIDTH and does not saturate.
- A zero request from any enabled source, e.g. the controller in pause mode, gives `emu_dt = 0`. In that cycle `emu_time` and `emu_step_cnt` hold.
- Reset has priority over all updates.
  - Reset asserted mid-run: on that clock edge, `emu_time`, `emu_step_cnt`, `emu_time_sat` and the stall state all return to 0.
  - `emu_dt` stays combinational during reset and still reflects the current requests.

## Timing

- `emu_dt` is purely combinational from `dt_req` and `dt_req_en`: zero latency, no register.
  - Implementation is a balanced min-reduction tree.
  - The `emu_rst`-to-`emu_dt` path must be free of logic.
- `emu_time`, `emu_step_cnt` and `emu_time_sat` change one cycle after the `emu_dt` value that caused the change.
- Reset values: `emu_time` = 0, `emu_step_cnt` = 0, `emu_time_sat` = 0, `emu_stall` = 0.
- First cycle after reset deasserts: `emu_time` still reads 0. It updates at the following edge.
- No handshake. Every cycle out of reset is a committed step.

## Configuration

- Macro `TM_STALL_DET_EN`.
- Defined: an internal counter of width `$clog2(STALL_THR+1)`.
  - Increments on each clocked cycle with `emu_dt == 0` and saturates at `STALL_THR`.
  - Clears to 0 on any cycle with `emu_dt != 0`, and on reset.
  - `emu_stall` is registered, and equals 1 exactly when the counter value is `STALL_THR`.
  - It therefore asserts on the edge that completes the STALL_THR-th consecutive zero step, and deasserts one edge after a nonzero step.
- Undefined: the `emu_stall` port and the counter do not exist; all other behaviour is identical.

## Test plan

- N_SRC=2, both enabled, requests 5 and 3, held for 4 cycles after reset → `emu_dt` = 3; `emu_time` reads 0, 3, 6, 9, 12; `emu_step_cnt` reads 4.
- Requests {7, 2} with `dt_req_en` = 2'b01 → `emu_dt` = 7. With `dt_req_en` = 2'b00 → `emu_dt` = all-ones.
- TIME_WIDTH=8, DT_WIDTH=8, `emu_time` = 250, `emu_dt` = 10 → next `emu_time` = 255 and `emu_time_sat` = 1. Both stay set with a further `emu_dt` of 0 or 1.
- Source 0 requests 0 for 3 cycles, then 4 → `emu_time` and `emu_step_cnt` hold for 3 cycles, then `emu_time` advances by 4 and `emu_step_cnt` by 1.
- `emu_rst` pulsed for 1 cycle at `emu_time` = 100, `emu_step_cnt` = 20 → both read 0 at the next edge; counting resumes from 0 after the pulse.
- With `TM_STALL_DET_EN` and `STALL_THR` = 4: zero requests for 4 cycles → `emu_stall` = 1 after the 4th edge. A following request of 1 → `emu_stall` = 0 one edge later.
